// File: rtl/cache_miss_controller.sv
// cache_miss_controller: main sequencer for one set-associative cache.
// Looks up CPU requests, completes hits, and on a miss writes back a dirty
// victim, refills the line word-by-word from memory, installs the tag and
// replays the lookup. Tag/data arrays live in the datapath; this block only
// drives their strobes and the replacement controller enable.
//
// Ports:
//   clk_i, rst_i          clock (rising edge), synchronous active-high reset
//   cpu_req_i/we_i/addr_i CPU request, held stable until cpu_ready_o
//   cpu_ready_o           one-cycle completion pulse
//   hit_i                 datapath tag compare result for the latched address
//   victim_dirty_i        dirty bit of the latched victim way
//   victim_base_i         line base address of the latched victim
//   replace_en_o          replacement controller enable
//   victim_latch_o        datapath captures the victim way index
//   word_sel_o            word index into the data array during transfers
//   fill_we_o             write mem_rdata into victim way at word_sel_o
//   cpu_we_o              write CPU word into the hit way, set dirty
//   tag_we_o              write tag, valid=1, dirty=0 into the victim way
//   mem_req_o/we_o/addr_o memory request, held until mem_ack_i
//   mem_ack_i             one-cycle ack per word
module cache_miss_controller #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned LINE_WORDS = 8
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic                              cpu_req_i,
   input  logic                              cpu_we_i,
   input  logic [ADDR_WIDTH-1:0]             cpu_addr_i,
   output logic                              cpu_ready_o,
   input  logic                              hit_i,
   input  logic                              victim_dirty_i,
   input  logic [ADDR_WIDTH-1:0]             victim_base_i,
   output logic                              replace_en_o,
   output logic                              victim_latch_o,
   output logic [$clog2(LINE_WORDS)-1:0]     word_sel_o,
   output logic                              fill_we_o,
   output logic                              cpu_we_o,
   output logic                              tag_we_o,
   output logic                              mem_req_o,
   output logic                              mem_we_o,
   output logic [ADDR_WIDTH-1:0]             mem_addr_o,
   input  logic                              mem_ack_i
);

   localparam int unsigned OFF   = $clog2(LINE_WORDS);
   localparam int unsigned TAG_W = ADDR_WIDTH - OFF - 2;
   localparam int unsigned unused_data_width = DATA_WIDTH;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOOKUP    = 3'd1,
      WRITEBACK = 3'd2,
      REFILL    = 3'd3,
      ALLOCATE  = 3'd4
   } state_t;

   state_t           state, state_n;
   logic [OFF-1:0]   cnt, cnt_n;
   logic [TAG_W-1:0] lat_line, lat_line_n;
   logic             lat_we, lat_we_n;
   logic             last_word;

   // Word-within-line and byte bits are rebuilt from cnt, so they are not needed here.
   logic unused_low_bits;
   assign unused_low_bits = ^{cpu_addr_i[OFF+1:0], victim_base_i[OFF+1:0]};

   assign last_word = (cnt == OFF'(LINE_WORDS - 1));

   // State, word counter and latched request.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= IDLE;
         cnt      <= '0;
         lat_line <= '0;
         lat_we   <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         lat_line <= lat_line_n;
         lat_we   <= lat_we_n;
      end
   end

   // Next-state and strobe decode; strobes react to hit_i/mem_ack_i in the same cycle.
   always_comb begin
      state_n        = state;
      cnt_n          = cnt;
      lat_line_n     = lat_line;
      lat_we_n       = lat_we;
      cpu_ready_o    = 1'b0;
      replace_en_o   = 1'b0;
      victim_latch_o = 1'b0;
      word_sel_o     = '0;
      fill_we_o      = 1'b0;
      cpu_we_o       = 1'b0;
      tag_we_o       = 1'b0;
      mem_req_o      = 1'b0;
      mem_we_o       = 1'b0;
      mem_addr_o     = '0;

      case (state)
         IDLE: begin
            if (cpu_req_i) begin
               lat_line_n = cpu_addr_i[ADDR_WIDTH-1:OFF+2];
               lat_we_n   = cpu_we_i;
               state_n    = LOOKUP;
            end
         end

         LOOKUP: begin
            replace_en_o = 1'b1;
            if (hit_i) begin
               cpu_ready_o = 1'b1;
               cpu_we_o    = lat_we;
               state_n     = IDLE;
            end else begin
               victim_latch_o = 1'b1;
               cnt_n          = '0;
               state_n        = victim_dirty_i ? WRITEBACK : REFILL;
            end
         end

         WRITEBACK: begin
            mem_req_o  = 1'b1;
            mem_we_o   = 1'b1;
            mem_addr_o = {victim_base_i[ADDR_WIDTH-1:OFF+2], cnt, 2'b00};
            word_sel_o = cnt;
            if (mem_ack_i) begin
               // Counter wraps to 0 on the last word, ready for the refill.
               cnt_n = cnt + OFF'(1);
               if (last_word) begin
                  state_n = REFILL;
               end
            end
         end

         REFILL: begin
            mem_req_o  = 1'b1;
            mem_addr_o = {lat_line, cnt, 2'b00};
            word_sel_o = cnt;
            fill_we_o  = mem_ack_i;
            if (mem_ack_i) begin
               cnt_n = cnt + OFF'(1);
               if (last_word) begin
                  state_n = ALLOCATE;
               end
            end
         end

         ALLOCATE: begin
            tag_we_o = 1'b1;
            state_n  = LOOKUP;
         end

         default: begin
            state_n = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_cache_miss_controller.sv
// tb_cache_miss_controller: directed bench for cache_miss_controller.
// A transaction-level model expands each request into the list of memory
// words it must produce and the cycle each strobe is due; a per-cycle check
// compares the DUT against it. Bench-side datapath and memory stand-ins
// drive hit_i (set after tag install) and mem_ack_i (zero-wait or random gaps).
module tb_cache_miss_controller;

   localparam int unsigned AW  = 32;
   localparam int unsigned DW  = 32;
   localparam int unsigned LW  = 8;
   localparam int unsigned OFF = 3;

   logic           clk_i = 1'b0;
   logic           rst_i;
   logic           cpu_req_i, cpu_we_i;
   logic [AW-1:0]  cpu_addr_i;
   logic           cpu_ready_o;
   logic           hit_i;
   logic           victim_dirty_i;
   logic [AW-1:0]  victim_base_i;
   logic           replace_en_o, victim_latch_o;
   logic [OFF-1:0] word_sel_o;
   logic           fill_we_o, cpu_we_o, tag_we_o;
   logic           mem_req_o, mem_we_o;
   logic [AW-1:0]  mem_addr_o;
   logic           mem_ack_i;

   cache_miss_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WORDS(LW)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
      .cpu_ready_o(cpu_ready_o), .hit_i(hit_i),
      .victim_dirty_i(victim_dirty_i), .victim_base_i(victim_base_i),
      .replace_en_o(replace_en_o), .victim_latch_o(victim_latch_o),
      .word_sel_o(word_sel_o), .fill_we_o(fill_we_o), .cpu_we_o(cpu_we_o),
      .tag_we_o(tag_we_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      int            idx;
   } op_t;

   op_t           q[$];
   int            n_cmp = 0, n_fail = 0;
   bit            active, hit0, cur_we, done, tag_seen, gap_rnd;
   int            cycle_no, last_pop, n_pops, fills, tags, gaps_total, ready_cycle, wait_left;
   logic [AW-1:0] first_addr, last_addr;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int next_gap();
      return gap_rnd ? int'($urandom_range(0, 5)) : 0;
   endfunction

   // Datapath and memory stand-ins, applied just after each rising edge.
   task automatic drive_models();
      if (tag_seen) hit_i = 1'b1;
      if (!mem_req_o) begin
         mem_ack_i = 1'b0;
         wait_left = next_gap();
      end else if (wait_left == 0) begin
         mem_ack_i = 1'b1;
         wait_left = next_gap();
      end else begin
         mem_ack_i = 1'b0;
         wait_left--;
         gaps_total++;
      end
   endtask

   // Per-cycle comparison against the transaction model.
   task automatic check_cycle();
      bit exp_req, exp_tag, exp_ready;
      if (!active) begin
         chk("idle_cpu_ready", cpu_ready_o, 0);
         chk("idle_replace_en", replace_en_o, 0);
         chk("idle_victim_latch", victim_latch_o, 0);
         chk("idle_fill_we", fill_we_o, 0);
         chk("idle_cpu_we", cpu_we_o, 0);
         chk("idle_tag_we", tag_we_o, 0);
         chk("idle_mem_req", mem_req_o, 0);
         return;
      end
      cycle_no++;
      exp_req = !hit0 && cycle_no >= 3 && q.size() > 0;
      chk("mem_req", mem_req_o, exp_req);
      if (exp_req) begin
         chk("mem_we", mem_we_o, q[0].we);
         chk("mem_addr", mem_addr_o, q[0].addr);
         chk("word_sel", word_sel_o, q[0].idx);
         chk("fill_we", fill_we_o, !q[0].we && mem_ack_i);
         if (mem_ack_i) begin
            if (n_pops == 0) first_addr = mem_addr_o;
            last_addr = mem_addr_o;
            void'(q.pop_front());
            last_pop = cycle_no;
            n_pops++;
         end
      end else begin
         chk("fill_we_off", fill_we_o, 0);
      end
      exp_tag   = !hit0 && q.size() == 0 && n_pops > 0 && cycle_no == last_pop + 1;
      exp_ready = hit0 ? (cycle_no == 2) : (q.size() == 0 && n_pops > 0 && cycle_no == last_pop + 2);
      chk("tag_we", tag_we_o, exp_tag);
      chk("cpu_ready", cpu_ready_o, exp_ready);
      chk("cpu_we", cpu_we_o, exp_ready && cur_we);
      chk("replace_en", replace_en_o, cycle_no == 2 || exp_ready);
      chk("victim_latch", victim_latch_o, !hit0 && cycle_no == 2);
      if (fill_we_o) fills++;
      if (tag_we_o) begin
         tags++;
         tag_seen = 1'b1;
      end
      if (cpu_ready_o) ready_cycle = cycle_no;
      if (cpu_ready_o || exp_ready) done = 1'b1;
   endtask

   task automatic idle_step();
      @(posedge clk_i); #1;
      drive_models();
      @(negedge clk_i);
      check_cycle();
   endtask

   // One CPU request. abort_after>0 raises rst_i in cycle abort_after+1.
   task automatic run_tx(input logic we, input logic [AW-1:0] addr, input bit hit_in,
                         input logic dirty, input logic [AW-1:0] vbase, input bit rnd,
                         input int lit_lat, input logic [AW-1:0] lit_first,
                         input logic [AW-1:0] lit_last, input int abort_after);
      logic [AW-1:0] line_mask;
      line_mask = AW'(LW * 4 - 1);
      @(posedge clk_i); #1;
      hit0 = hit_in; cur_we = we; gap_rnd = rnd;
      q.delete();
      if (!hit_in) begin
         if (dirty)
            for (int i = 0; i < int'(LW); i++)
               q.push_back('{we: 1'b1, addr: vbase + AW'(4 * i), idx: i});
         for (int i = 0; i < int'(LW); i++)
            q.push_back('{we: 1'b0, addr: (addr & ~line_mask) + AW'(4 * i), idx: i});
      end
      cycle_no = 0; last_pop = -10; n_pops = 0; fills = 0; tags = 0;
      gaps_total = 0; ready_cycle = -1; done = 1'b0; tag_seen = 1'b0;
      hit_i = hit_in; victim_dirty_i = dirty; victim_base_i = vbase;
      cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr;
      active = 1'b1;
      drive_models();
      for (int c = 0; c < 400 && !done; c++) begin
         @(negedge clk_i);
         check_cycle();
         if (abort_after > 0 && cycle_no == abort_after + 1) break;
         if (!done) begin
            @(posedge clk_i); #1;
            drive_models();
            if (abort_after > 0 && cycle_no == abort_after) begin
               rst_i = 1'b1;
               cpu_req_i = 1'b0;
            end
         end
      end
      if (abort_after > 0) begin
         @(posedge clk_i); #1;
         rst_i = 1'b0;
         active = 1'b0;
         q.delete();
         drive_models();
         @(negedge clk_i);
         check_cycle();
         chk("abort_mem_req", mem_req_o, 0);
         chk("abort_tag_count", tags, 0);
         chk("abort_words_done", n_pops, 4);
      end else if (!done) begin
         n_cmp++; n_fail++;
         $display("FAIL timeout: no cpu_ready_o within 400 cycles (addr 0x%0h)", addr);
         active = 1'b0; cpu_req_i = 1'b0; rst_i = 1'b1;
         repeat (2) @(posedge clk_i);
         #1 rst_i = 1'b0;
      end else begin
         chk("latency_formula", ready_cycle, hit_in ? 2 : 4 + n_pops + gaps_total);
         if (lit_lat > 0) chk("latency_literal", ready_cycle, lit_lat);
         chk("fill_count", fills, hit_in ? 0 : int'(LW));
         chk("tag_count", tags, hit_in ? 0 : 1);
         if (lit_first != '0) chk("first_mem_addr", first_addr, lit_first);
         if (lit_last != '0) chk("last_mem_addr", last_addr, lit_last);
         @(posedge clk_i); #1;
         cpu_req_i = 1'b0;
         active = 1'b0;
         drive_models();
         @(negedge clk_i);
         check_cycle();
      end
   endtask

   initial begin
      rst_i = 1'b1; cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0;
      hit_i = 1'b0; victim_dirty_i = 1'b0; victim_base_i = '0; mem_ack_i = 1'b0;
      active = 1'b0; tag_seen = 1'b0; gap_rnd = 1'b0; wait_left = 0; gaps_total = 0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      check_cycle();
      chk("reset_mem_addr", mem_addr_o, 0);
      chk("reset_word_sel", word_sel_o, 0);
      chk("reset_mem_we", mem_we_o, 0);
      @(posedge clk_i); #1 rst_i = 1'b0;
      idle_step();

      // we, addr, hit, dirty, victim_base, rnd, lat, first, last, abort
      run_tx(1'b0, 32'h0000_0100, 1'b1, 1'b0, 32'h0,         1'b0, 2,  32'h0,         32'h0,         0);
      run_tx(1'b1, 32'h0000_0104, 1'b1, 1'b0, 32'h0,         1'b0, 2,  32'h0,         32'h0,         0);
      run_tx(1'b0, 32'h0000_1234, 1'b0, 1'b0, 32'h0,         1'b0, 12, 32'h0000_1220, 32'h0000_123C, 0);
      run_tx(1'b0, 32'h0000_4A10, 1'b0, 1'b1, 32'h0000_8000, 1'b0, 20, 32'h0000_8000, 32'h0000_4A1C, 0);
      run_tx(1'b1, 32'h0000_2008, 1'b0, 1'b0, 32'h0,         1'b0, 12, 32'h0000_2000, 32'h0000_201C, 0);
      run_tx(1'b1, 32'h0001_0F44, 1'b0, 1'b1, 32'h0000_C0E0, 1'b1, 0,  32'h0000_C0E0, 32'h0001_0F5C, 0);
      run_tx(1'b0, 32'h0000_3330, 1'b0, 1'b0, 32'h0,         1'b1, 0,  32'h0000_3320, 32'h0000_333C, 0);
      run_tx(1'b0, 32'h0000_5000, 1'b0, 1'b0, 32'h0,         1'b0, 0,  32'h0,         32'h0,         5);
      run_tx(1'b0, 32'h0000_5004, 1'b0, 1'b0, 32'h0,         1'b0, 12, 32'h0000_5000, 32'h0000_501C, 0);
      idle_step();
      idle_step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
